// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg: shared definitions for the data-memory path.
//   XLEN / NB     : data width in bits and the number of byte lanes per word.
//   SIZE_*        : one-hot access-size encodings carried on access_size_i.
//   sb_entry_t    : store-buffer entry {word index, lane-aligned data, byte enables}.
//   size_legal()  : tells whether a size/alignment pair is a legal access.
//   lane_be()     : gives the byte-lane enables for a legal access.
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NB    = XLEN / 8;
  // The index field holds a full word address so the entry layout does not
  // depend on the array depth. Only the low bits are ever populated.
  localparam int IDX_W = XLEN - 2;

  localparam logic [2:0] SIZE_B = 3'b001;
  localparam logic [2:0] SIZE_H = 3'b010;
  localparam logic [2:0] SIZE_W = 3'b100;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [XLEN-1:0]  data;
    logic [NB-1:0]    be;
  } sb_entry_t;

  function automatic logic size_legal(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SIZE_B:  return 1'b1;
      SIZE_H:  return ~lo[0];
      SIZE_W:  return (lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NB-1:0] lane_be(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SIZE_B:  return NB'(4'b0001) << lo;
      SIZE_H:  return NB'(4'b0011) << lo;
      SIZE_W:  return '1;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if: core data-port request/response bundle.
//   adr_v_i       : request valid this cycle.
//   adr_i         : byte address.
//   is_store_i    : 1 = store, 0 = load.
//   store_data_i  : store data, right-justified.
//   access_size_i : SIZE_B / SIZE_H / SIZE_W.
//   load_data_o   : load result, right-justified and zero-filled (same cycle).
// Modports: master = core side, slave = memory side.
// -----------------------------------------------------------------------------
interface dmem_if
  import riscv_pkg::*;
();

  logic            adr_v_i;
  logic [XLEN-1:0] adr_i;
  logic            is_store_i;
  logic [XLEN-1:0] store_data_i;
  logic [2:0]      access_size_i;
  logic [XLEN-1:0] load_data_o;

  modport master (
    output adr_v_i, adr_i, is_store_i, store_data_i, access_size_i,
    input  load_data_o
  );

  modport slave (
    input  adr_v_i, adr_i, is_store_i, store_data_i, access_size_i,
    output load_data_o
  );

endinterface

// File: rtl/dmem_store_buf.sv
// -----------------------------------------------------------------------------
// dmem_store_buf: posted-store FIFO with per-lane youngest-match forwarding.
//   clk, reset_n   : clock, asynchronous active-low reset.
//   push_i         : write push_entry_i at the tail.
//   push_entry_i   : entry to push.
//   pop_i          : retire the head entry (caller guarantees non-empty).
//   lookup_idx_i   : word index of the load being served.
//   head_o         : oldest entry, to be written into the array on a pop.
//   fwd_data_o     : forwarded bytes, lane-aligned.
//   fwd_be_o       : lanes for which fwd_data_o is valid.
//   empty_o/full_o : occupancy flags derived from the registered count.
// Push and pop may both be asserted when full; occupancy then stays full.
// -----------------------------------------------------------------------------
module dmem_store_buf
  import riscv_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  sb_entry_t        push_entry_i,
  input  logic             pop_i,
  input  logic [IDX_W-1:0] lookup_idx_i,
  output sb_entry_t        head_o,
  output logic [XLEN-1:0]  fwd_data_o,
  output logic [NB-1:0]    fwd_be_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = $clog2(SB_DEPTH);

  sb_entry_t       entries [SB_DEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [PW:0]     count_q;
  logic [PW-1:0]   slot;

  // Pointers are PW bits wide over a power-of-two depth, so they wrap by
  // natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i)  head_q <= head_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: entry storage has no reset; validity comes solely from count_q, so
  // clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_i) entries[tail_q] <= push_entry_i;
  end

  // Walk from oldest to youngest so a younger match overwrites an older one
  // lane by lane.
  // NOTE: combinational blocks use blocking assignments with a default at the
  // top, so every path assigns every output and no latch is inferred.
  always_comb begin
    fwd_data_o = '0;
    fwd_be_o   = '0;
    slot       = head_q;
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (entries[slot].index == lookup_idx_i)) begin
        for (int b = 0; b < NB; b++) begin
          if (entries[slot].be[b]) begin
            fwd_data_o[8*b +: 8] = entries[slot].data[8*b +: 8];
            fwd_be_o[b]          = 1'b1;
          end
        end
      end
    end
  end

  assign head_o  = entries[head_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(SB_DEPTH));

endmodule

// File: rtl/dmem.sv
// -----------------------------------------------------------------------------
// dmem: data-memory responder for the core data port.
//   clk, reset_n  : clock, asynchronous active-low reset.
//   bus           : dmem_if.slave request/response bundle.
//   misalign_q_o  : one-cycle pulse the cycle after an illegal/misaligned request.
//   sb_empty_o    : store buffer empty.
//   ld_cnt_q_o    : accepted-load count   (only with DMEM_PERF_CNT_EN).
//   st_cnt_q_o    : accepted-store count  (only with DMEM_PERF_CNT_EN).
// Loads are answered combinationally from the array merged with forwarded
// store-buffer bytes. Stores are posted to the buffer and written into the
// array one at a time when the port is idle, or when a store meets a full
// buffer (drain head and push tail together).
// Optional feature macro: DMEM_PERF_CNT_EN (performance counters).
// -----------------------------------------------------------------------------
module dmem
  import riscv_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  dmem_if.slave       bus,
  output logic        misalign_q_o,
  output logic        sb_empty_o
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] ld_cnt_q_o,
  output logic [31:0] st_cnt_q_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0]  mem [DEPTH];

  logic [1:0]       lo;
  logic [AW-1:0]    widx;
  logic             legal;
  logic             ld_acc;
  logic             st_acc;
  logic             drain;
  logic             sb_full;
  logic             sb_empty;
  sb_entry_t        push_entry;
  sb_entry_t        head;
  logic [XLEN-1:0]  fwd_data;
  logic [NB-1:0]    fwd_be;
  logic [XLEN-1:0]  merged;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  size_mask;

  assign lo     = bus.adr_i[1:0];
  assign widx   = bus.adr_i[AW+1:2];
  assign legal  = size_legal(bus.access_size_i, lo);
  assign ld_acc = bus.adr_v_i & legal & ~bus.is_store_i;
  assign st_acc = bus.adr_v_i & legal &  bus.is_store_i;

  // A store into a full buffer retires the head in the same cycle, so it
  // never stalls; a load never drains and is served by forwarding instead.
  assign drain  = ~sb_empty & (~bus.adr_v_i | (st_acc & sb_full));

  // Shifting by the byte offset places halfwords and bytes in their lanes;
  // bytes above the access size land in disabled lanes and are never written.
  assign push_entry.index = {{(IDX_W-AW){1'b0}}, widx};
  assign push_entry.data  = bus.store_data_i << {lo, 3'b000};
  assign push_entry.be    = lane_be(bus.access_size_i, lo);

  dmem_store_buf #(
    .SB_DEPTH (SB_DEPTH)
  ) u_store_buf (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (st_acc),
    .push_entry_i (push_entry),
    .pop_i        (drain),
    .lookup_idx_i (push_entry.index),
    .head_o       (head),
    .fwd_data_o   (fwd_data),
    .fwd_be_o     (fwd_be),
    .empty_o      (sb_empty),
    .full_o       (sb_full)
  );

  // Single write port: only the drained head entry reaches the array.
  always_ff @(posedge clk) begin
    if (drain) begin
      for (int b = 0; b < NB; b++) begin
        if (head.be[b]) mem[head.index[AW-1:0]][8*b +: 8] <= head.data[8*b +: 8];
      end
    end
  end

  always_comb begin
    merged = mem[widx];
    for (int b = 0; b < NB; b++) begin
      if (fwd_be[b]) merged[8*b +: 8] = fwd_data[8*b +: 8];
    end
  end

  always_comb begin
    case (bus.access_size_i)
      SIZE_B:  size_mask = 32'h0000_00FF;
      SIZE_H:  size_mask = 32'h0000_FFFF;
      SIZE_W:  size_mask = 32'hFFFF_FFFF;
      default: size_mask = '0;
    endcase
  end

  assign shifted         = merged >> {lo, 3'b000};
  assign bus.load_data_o = ld_acc ? (shifted & size_mask) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign_q_o <= 1'b0;
    else          misalign_q_o <= bus.adr_v_i & ~legal;
  end

  assign sb_empty_o = sb_empty;

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_cnt_q_o <= '0;
      st_cnt_q_o <= '0;
    end else begin
      if (ld_acc) ld_cnt_q_o <= ld_cnt_q_o + 32'd1;
      if (st_acc) st_cnt_q_o <= st_cnt_q_o + 32'd1;
    end
  end
`endif

  // Address bits above the array and index bits above AW are aliased away.
  logic unused_bits;
  assign unused_bits = ^{bus.adr_i[XLEN-1:AW+2], head.index[IDX_W-1:AW]};

endmodule

// File: tb/tb_dmem.sv
// -----------------------------------------------------------------------------
// tb_dmem: self-checking bench for dmem. The reference keeps the memory as a
// byte array as software sees it, a byte array of what has reached the RAM,
// and a queue of posted stores; a reset drops the queue and reverts the view.
// -----------------------------------------------------------------------------
module tb_dmem;
  import riscv_pkg::*;

  localparam int DEPTH = 1024;
  localparam int SB    = 4;
  localparam int NBYTE = DEPTH * 4;

  typedef struct {
    int unsigned addr;
    int unsigned n;
    logic [31:0] val;
  } pend_t;

  logic clk = 1'b0;
  logic reset_n;
  logic misalign_q_o;
  logic sb_empty_o;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] ld_cnt_q_o;
  logic [31:0] st_cnt_q_o;
`endif

  dmem_if bus ();

  dmem #(.DEPTH(DEPTH), .SB_DEPTH(SB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .misalign_q_o (misalign_q_o),
    .sb_empty_o   (sb_empty_o)
`ifdef DMEM_PERF_CNT_EN
    ,
    .ld_cnt_q_o   (ld_cnt_q_o),
    .st_cnt_q_o   (st_cnt_q_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  arch [NBYTE];
  logic [7:0]  ram  [NBYTE];
  pend_t       pend [$];
  logic        exp_mis;
  logic [31:0] exp_ld_cnt;
  logic [31:0] exp_st_cnt;

  logic [31:0] last_load;
  logic        last_empty;
  logic        last_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ref_legal(input logic [2:0] sz, input logic [31:0] a);
    if (sz == 3'd1) return 1'b1;
    if (sz == 3'd2) return (a % 2) == 0;
    if (sz == 3'd4) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic int unsigned ref_bytes(input logic [2:0] sz);
    return (sz == 3'd1) ? 1 : (sz == 3'd2) ? 2 : 4;
  endfunction

  // One bus cycle: apply inputs just after a rising edge, compare at the
  // falling edge, then advance the reference on the next rising edge.
  task automatic step(input logic v, input logic [31:0] a, input logic st,
                      input logic [31:0] d, input logic [2:0] sz);
    logic        ok;
    int unsigned base;
    int unsigned n;
    logic [31:0] exp_load;
    logic        do_drain;
    pend_t       e;

    bus.adr_v_i       = v;
    bus.adr_i         = a;
    bus.is_store_i    = st;
    bus.store_data_i  = d;
    bus.access_size_i = sz;

    ok   = v && ref_legal(sz, a);
    base = a % NBYTE;
    n    = ref_bytes(sz);
    exp_load = 32'd0;
    if (ok && !st)
      for (int k = 0; k < int'(n); k++) exp_load = exp_load + (32'(arch[base + k]) << (8 * k));

    @(negedge clk);
    check("load_data", bus.load_data_o, exp_load);
    check("sb_empty", {31'd0, sb_empty_o}, {31'd0, pend.size() == 0});
    check("misalign", {31'd0, misalign_q_o}, {31'd0, exp_mis});
`ifdef DMEM_PERF_CNT_EN
    check("ld_cnt", ld_cnt_q_o, exp_ld_cnt);
    check("st_cnt", st_cnt_q_o, exp_st_cnt);
`endif
    last_load  = bus.load_data_o;
    last_empty = sb_empty_o;
    last_mis   = misalign_q_o;

    @(posedge clk);
    do_drain = (pend.size() > 0) && (!v || (ok && st && pend.size() == SB));
    if (do_drain) begin
      e = pend.pop_front();
      for (int k = 0; k < int'(e.n); k++) ram[e.addr + k] = e.val[8*k +: 8];
    end
    if (ok && st) begin
      e.addr = base;
      e.n    = n;
      e.val  = d;
      pend.push_back(e);
      for (int k = 0; k < int'(n); k++) arch[base + k] = d[8*k +: 8];
    end
    exp_mis = v && !ref_legal(sz, a);
    if (ok &&  st) exp_st_cnt = exp_st_cnt + 1;
    if (ok && !st) exp_ld_cnt = exp_ld_cnt + 1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0, SIZE_W);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    step(1'b1, a, 1'b1, d, sz);
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] sz);
    step(1'b1, a, 1'b0, 32'hFFFF_FFFF, sz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  sz;
    logic [31:0] a;
    int          r;

    for (int i = 0; i < NBYTE; i++) begin
      arch[i] = 8'h00;
      ram[i]  = 8'h00;
    end
    exp_mis    = 1'b0;
    exp_ld_cnt = '0;
    exp_st_cnt = '0;

    bus.adr_v_i       = 1'b0;
    bus.adr_i         = '0;
    bus.is_store_i    = 1'b0;
    bus.store_data_i  = '0;
    bus.access_size_i = SIZE_W;
    reset_n = 1'b0;
    #12;
    check("rst_sb_empty", {31'd0, sb_empty_o}, 32'd1);
    check("rst_misalign", {31'd0, misalign_q_o}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Give the 16-word test window known zero contents.
    for (int w = 0; w < 16; w++) store(32'(w * 4), 32'd0, SIZE_W);
    idle(SB + 1);

    // Store then load, word.
    store(32'h10, 32'hDEAD_BEEF, SIZE_W);
    idle(1);
    load(32'h10, SIZE_W);
    check("word_rt", last_load, 32'hDEAD_BEEF);
    check("word_rt_empty", {31'd0, last_empty}, 32'd1);

    // Byte forwarding.
    store(32'h13, 32'h0000_00AA, SIZE_B);
    load(32'h10, SIZE_W);
    check("byte_fwd_word", last_load, 32'hAAAD_BEEF);
    load(32'h13, SIZE_B);
    check("byte_fwd_byte", last_load, 32'h0000_00AA);
    idle(2);

    // Full buffer: fifth store drains the head while pushing.
    for (int i = 0; i < 5; i++) store(32'(i * 4), 32'h1111_0000 + 32'(i), SIZE_W);
    check("full_not_empty", {31'd0, last_empty}, 32'd0);
    idle(4);
    check("full_last_idle_pending", {31'd0, last_empty}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      load(32'(i * 4), SIZE_W);
      check("full_readback", last_load, 32'h1111_0000 + 32'(i));
      if (i == 0) check("full_drained", {31'd0, last_empty}, 32'd1);
    end

    // Lane merge: youngest entry owns lane 1.
    store(32'h20, 32'h0000_1234, SIZE_H);
    store(32'h21, 32'h0000_0056, SIZE_B);
    load(32'h20, SIZE_W);
    check("lane_merge", last_load, 32'h0000_5634);
    idle(3);

    // Misaligned requests.
    load(32'h11, SIZE_H);
    check("mis_load_zero", last_load, 32'd0);
    idle(1);
    check("mis_pulse", {31'd0, last_mis}, 32'd1);
    idle(1);
    check("mis_pulse_end", {31'd0, last_mis}, 32'd0);
    store(32'h22, 32'hCAFE_F00D, SIZE_W);
    idle(1);
    check("mis_store_no_push", {31'd0, last_empty}, 32'd1);
    check("mis_store_pulse", {31'd0, last_mis}, 32'd1);
    load(32'h20, SIZE_W);
    check("mis_store_no_write", last_load, 32'h0000_5634);

    // Randomised traffic, confined to the window but with random alias bits.
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)      sz = 3'($urandom_range(0, 7));
      else if (r < 6)  sz = SIZE_B;
      else if (r < 10) sz = SIZE_H;
      else             sz = SIZE_W;
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      if (sz == SIZE_H && r != 0) a[0] = 1'b0;
      if (sz == SIZE_W && r != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) idle(1);
      else step(1'b1, a, 1'($urandom_range(0, 1)), $urandom, sz);
    end

    // Reset with three stores pending and a misalign pulse in flight.
    idle(SB + 1);
    store(32'h30, 32'h0102_0304, SIZE_W);
    store(32'h34, 32'h0506_0708, SIZE_W);
    store(32'h38, 32'h090A_0B0C, SIZE_W);
    load(32'h3B, SIZE_W);
    bus.adr_v_i = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_empty", {31'd0, sb_empty_o}, 32'd1);
    check("rst_mid_misalign", {31'd0, misalign_q_o}, 32'd0);
`ifdef DMEM_PERF_CNT_EN
    check("rst_mid_ld_cnt", ld_cnt_q_o, 32'd0);
    check("rst_mid_st_cnt", st_cnt_q_o, 32'd0);
`endif
    pend.delete();
    for (int i = 0; i < NBYTE; i++) arch[i] = ram[i];
    exp_mis    = 1'b0;
    exp_ld_cnt = '0;
    exp_st_cnt = '0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int w = 12; w < 16; w++) load(32'(w * 4), SIZE_W);
    for (int c = 0; c < 100; c++)
      step(1'b1, 32'($urandom_range(0, 63)) & ~32'd3, 1'($urandom_range(0, 1)), $urandom, SIZE_W);
    idle(SB + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
